// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Shared definitions for the rv32 fetch path: default reset PC and bubble
//   instruction, fetch FSM state encodings, the {pc,instr} queue entry type
//   and a word-alignment helper.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam int unsigned BUF_DEPTH_DEFAULT = 2;

  // Fetch FSM encodings
  localparam logic [1:0] FETCH_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_REQ   = 2'd1;
  localparam logic [1:0] FETCH_RSP   = 2'd2;
  localparam logic [1:0] FETCH_DRAIN = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo
//   DEPTH-entry queue of {pc,instr} words between instruction memory and the
//   decode register. DEPTH must be a power of two so the pointers wrap freely.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   push/push_data write one entry (accepted when not full, or when a pop
//                  happens in the same cycle)
//   pop            remove head entry (ignored when empty)
//   flush          discard all entries; wins over push and pop
//   head           current head entry (contents undefined when empty)
//   full, empty    occupancy flags
module instr_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A push into a full queue is still fine when the head leaves the same cycle.
  assign pop_en  = pop && !empty && !flush;
  assign push_en = push && !flush && (!full || pop_en);

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_en && !pop_en)      count_d = count_q + CW'(1);
      else if (!push_en && pop_en) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   rv32 instruction fetch. Owns the PC, keeps at most one request outstanding
//   to instruction memory, queues returned words in instr_fifo and loads the
//   fetch->decode register.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pc_sel, br_target        redirect the PC (low two target bits ignored)
//   false_path               wrong path: flush queue, in-flight fetch, decode reg
//   stall                    hold decode register and queue head
//   imem_req/addr/gnt        request channel to instruction memory
//   imem_rvalid/rdata        response channel (one response per grant)
//   instr_fetch, pc_fetch    queue head (NOP_INSTR / 0 when empty)
//   instr_de, pc_de, pc_4_de decode register contents
//   valid_de                 decode register holds a real instruction
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel,
  input  logic        false_path,
  input  logic        stall,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_fetch,
  output logic [31:0] pc_fetch,
  output logic [31:0] instr_de,
  output logic [31:0] pc_de,
  output logic [31:0] pc_4_de,
  output logic        valid_de
);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_req_q, pc_req_d;
  logic [31:0]  instr_de_q, instr_de_d;
  logic [31:0]  pc_de_q, pc_de_d;
  logic         valid_de_q, valid_de_d;

  logic         kill;
  logic         push, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t fifo_head, push_data;

  // Either a redirect or a wrong-path flush invalidates the in-flight word.
  assign kill = pc_sel | false_path;

  // Only one request can be outstanding, so in REQ nothing is in flight and
  // a free queue slot is enough to guarantee room for the response.
  assign imem_req  = (state_q == FETCH_REQ) && !fifo_full;
  assign imem_addr = pc_q;

  assign push_data.pc    = pc_req_q;
  assign push_data.instr = imem_rdata;

  assign pop = !stall && !false_path && !fifo_empty;

  instr_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (false_path),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fetch FSM and PC. A grant that coincides with a kill is still owed a
  // response by memory, so DRAIN swallows it before the next request.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_req_d = pc_req_q;
    push     = 1'b0;
    if (pc_sel) pc_d = word_align(br_target);
    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (imem_req && imem_gnt) begin
          pc_req_d = pc_q;
          if (!pc_sel) pc_d = pc_q + 32'd4;
          state_d = kill ? FETCH_DRAIN : FETCH_RSP;
        end
      end
      FETCH_RSP: begin
        if (imem_rvalid) begin
          push    = !kill;
          state_d = FETCH_REQ;
        end else if (kill) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rvalid) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // Decode register: flush beats stall; otherwise load the head or a bubble.
  always_comb begin
    instr_de_d = instr_de_q;
    pc_de_d    = pc_de_q;
    valid_de_d = valid_de_q;
    if (false_path) begin
      instr_de_d = NOP_INSTR;
      valid_de_d = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instr_de_d = fifo_head.instr;
        pc_de_d    = fifo_head.pc;
        valid_de_d = 1'b1;
      end else begin
        instr_de_d = NOP_INSTR;
        valid_de_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= word_align(RESET_PC);
      pc_req_q   <= '0;
      instr_de_q <= NOP_INSTR;
      pc_de_q    <= '0;
      valid_de_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_req_q   <= pc_req_d;
      instr_de_q <= instr_de_d;
      pc_de_q    <= pc_de_d;
      valid_de_q <= valid_de_d;
    end
  end

  assign instr_fetch = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign pc_fetch    = fifo_empty ? 32'd0 : fifo_head.pc;
  assign instr_de    = instr_de_q;
  assign pc_de       = pc_de_q;
  assign pc_4_de     = pc_de_q + 32'd4;
  assign valid_de    = valid_de_q;

endmodule
